// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage_if
//  Purpose  : Execute-to-write-back bus for the MEM/WB pipeline stage, plus
//             the inspection port into the stage's data memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if;
    logic [7:0] ans_ex;
    logic [7:0] B_Bypass;
    logic       mem_en_ex;
    logic       mem_rw_ex;
    logic       mem_mux_sel_ex;
    logic [4:0] RW_ex;
    logic [7:0] dbg_addr;
    logic [7:0] wb_data;
    logic [4:0] RW_wb;
    logic       ld_hit;
    logic [7:0] dbg_data;

    // Upstream side: presents the execute-stage results, observes write-back
    modport master (
        output ans_ex, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex, dbg_addr,
        input  wb_data, RW_wb, ld_hit, dbg_data
    );

    // Stage side: consumes execute-stage results, produces write-back
    modport slave (
        input  ans_ex, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex, dbg_addr,
        output wb_data, RW_wb, ld_hit, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : Memory-access / write-back pipeline stage with a 256x8 data
//             memory. Stores write on the clock edge, loads read the pre-edge
//             contents and register them into the write-back path.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage (
    input  wire logic          clk,
    input  wire logic          reset,   // asynchronous, active low
    mem_wb_stage_if.slave      bus
);
    localparam int c_DEPTH = 256;

    // Data memory; intentionally has no reset so contents survive it
    logic [7:0] r_mem [c_DEPTH];

    logic [7:0] r_wb_data;
    logic [4:0] r_rw_wb;
    logic       r_ld_hit;

    logic       w_load;
    logic       w_store;
    logic [7:0] w_wb_next;
    logic [4:0] w_rw_next;

    assign w_load  = bus.mem_en_ex & ~bus.mem_rw_ex;
    assign w_store = bus.mem_en_ex &  bus.mem_rw_ex;

    // Select write-back data; a memory-sourced write-back with no load behind
    // it has nothing valid to write, so the register write enable is dropped
    always_comb begin
        w_wb_next = bus.ans_ex;
        w_rw_next = bus.RW_ex;
        if (bus.mem_mux_sel_ex) begin
            if (w_load) begin
                w_wb_next = r_mem[bus.ans_ex];
            end else begin
                w_wb_next = 8'h00;
                w_rw_next = {1'b0, bus.RW_ex[3:0]};
            end
        end
    end

    // Memory write port; a store on an edge where reset is held is discarded
    always_ff @(posedge clk) begin
        if (reset && w_store) begin
            r_mem[bus.ans_ex] <= bus.B_Bypass;
        end
    end

    // Stage register with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_data <= 8'h00;
            r_rw_wb   <= 5'h00;
            r_ld_hit  <= 1'b0;
        end else begin
            r_wb_data <= w_wb_next;
            r_rw_wb   <= w_rw_next;
            r_ld_hit  <= w_load;
        end
    end

    assign bus.wb_data  = r_wb_data;
    assign bus.RW_wb    = r_rw_wb;
    assign bus.ld_hit   = r_ld_hit;
    assign bus.dbg_data = r_mem[bus.dbg_addr];
endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Directed self-checking bench for mem_wb_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rw, input logic sel,
                         input logic [7:0] ans, input logic [7:0] dat, input logic [4:0] rw_ex);
        bus.mem_en_ex      = en;
        bus.mem_rw_ex      = rw;
        bus.mem_mux_sel_ex = sel;
        bus.ans_ex         = ans;
        bus.B_Bypass       = dat;
        bus.RW_ex          = rw_ex;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.dbg_addr = 8'h10;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00);

        // Reset state, before any clock edge
        #2;
        chk("rst_wb",  {24'h0, bus.wb_data}, 32'h00);
        chk("rst_rw",  {27'h0, bus.RW_wb},   32'h00);
        chk("rst_ld",  {31'h0, bus.ld_hit},  32'h0);
        step();
        chk("rst_hold_wb", {24'h0, bus.wb_data}, 32'h00);
        reset = 1'b1;

        // Store 0x10 <= A5 with sel=0
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 5'h00);
        step();
        chk("st_dbg",   {24'h0, bus.dbg_data}, 32'hA5);
        chk("st_wb",    {24'h0, bus.wb_data},  32'h10);
        chk("st_ld",    {31'h0, bus.ld_hit},   32'h0);

        // Load 0x10 on the very next edge
        drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 5'h13);
        step();
        chk("ld_wb",  {24'h0, bus.wb_data}, 32'hA5);
        chk("ld_rw",  {27'h0, bus.RW_wb},   32'h13);
        chk("ld_hit", {31'h0, bus.ld_hit},  32'h1);

        // Store 0x3C <= 99 (sel=0 passes address; RW unchanged)
        drive(1'b1, 1'b1, 1'b0, 8'h3C, 8'h99, 5'h1B);
        step();
        chk("ld_hit_drop", {31'h0, bus.ld_hit}, 32'h0);
        chk("st_sel0_wb",  {24'h0, bus.wb_data}, 32'h3C);
        chk("st_sel0_rw",  {27'h0, bus.RW_wb},   32'h1B);

        // ALU pass-through, memory untouched
        bus.dbg_addr = 8'h3C;
        drive(1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 5'h12);
        step();
        chk("alu_wb",  {24'h0, bus.wb_data},  32'h3C);
        chk("alu_rw",  {27'h0, bus.RW_wb},    32'h12);
        chk("alu_dbg", {24'h0, bus.dbg_data}, 32'h99);

        // Store to 0xFF with sel=1: write-back suppressed
        bus.dbg_addr = 8'hFF;
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h77, 5'h1F);
        step();
        chk("stff_wb",  {24'h0, bus.wb_data},  32'h00);
        chk("stff_rw",  {27'h0, bus.RW_wb},    32'h0F);
        chk("stff_dbg", {24'h0, bus.dbg_data}, 32'h77);

        // sel=1 with access disabled also suppresses write-back
        drive(1'b0, 1'b0, 1'b1, 8'h44, 8'h00, 5'h16);
        step();
        chk("nomem_wb", {24'h0, bus.wb_data}, 32'h00);
        chk("nomem_rw", {27'h0, bus.RW_wb},   32'h06);

        // Disabled write must not touch memory
        bus.dbg_addr = 8'h10;
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'hFF, 5'h00);
        step();
        chk("dis_dbg", {24'h0, bus.dbg_data}, 32'hA5);
        chk("dis_wb",  {24'h0, bus.wb_data},  32'h10);

        // Back-to-back stores to 0x20, then load
        bus.dbg_addr = 8'h20;
        drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h01, 5'h00);
        step();
        chk("ovw1_dbg", {24'h0, bus.dbg_data}, 32'h01);
        drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h02, 5'h00);
        step();
        chk("ovw2_dbg", {24'h0, bus.dbg_data}, 32'h02);
        drive(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 5'h15);
        step();
        chk("ovw_ld_wb", {24'h0, bus.wb_data}, 32'h02);
        chk("ovw_ld_rw", {27'h0, bus.RW_wb},   32'h15);

        // Load of 0xFF
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 5'h10);
        step();
        chk("ldff_wb", {24'h0, bus.wb_data}, 32'h77);

        // Mid-operation reset
        drive(1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 5'h1A);
        step();
        chk("pre_rst_wb", {24'h0, bus.wb_data}, 32'h5A);
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 8'h00, 5'h1A); // load pending so ld_hit goes 1
        step();
        chk("pre_rst_ld", {31'h0, bus.ld_hit}, 32'h1);
        bus.dbg_addr = 8'h10;
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h33, 5'h1E);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_wb", {24'h0, bus.wb_data}, 32'h00);
        chk("arst_rw", {27'h0, bus.RW_wb},   32'h00);
        chk("arst_ld", {31'h0, bus.ld_hit},  32'h0);
        step();
        step();
        chk("rst_store_dbg", {24'h0, bus.dbg_data}, 32'hA5);
        chk("rst_held_wb",   {24'h0, bus.wb_data},  32'h00);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 5'h11);
        step();
        chk("post_rst_wb", {24'h0, bus.wb_data}, 32'hA5);
        chk("post_rst_rw", {27'h0, bus.RW_wb},   32'h11);
        chk("post_rst_ld", {31'h0, bus.ld_hit},  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
